// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for a MIPS subset datapath: sequences fetch, decode, execute,
// memory and writeback states and drives the datapath enables, selects and ALU op.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_op,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        mem_re,
  output logic        mem_we,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] icount,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWr   = 4'd6,
    StWbAlu   = 4'd7,
    StWbMem   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] icount_q, icount_d;

  logic [5:0] op, funct;
  logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic       unused_instr;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  assign is_r    = (op == 6'b000000);
  assign is_addu = is_r && (funct == 6'b100001);
  assign is_subu = is_r && (funct == 6'b100011);
  assign is_jr   = is_r && (funct == 6'b001000);
  assign is_ori  = (op == 6'b001101);
  assign is_lui  = (op == 6'b001111);
  assign is_lw   = (op == 6'b100011);
  assign is_sw   = (op == 6'b101011);
  assign is_beq  = (op == 6'b000100);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);

  always_comb begin
    state_d    = StFetch;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        alu_src_b = 2'b01;
        state_d   = StDecode;
      end
      StDecode: begin
        // Speculatively form the branch target into ALUOut.
        alu_src_b = 2'b11;
        if (is_addu || is_subu)           state_d = StExecR;
        else if (is_ori || is_lui)        state_d = StExecI;
        else if (is_lw || is_sw)          state_d = StMemAddr;
        else if (is_beq)                  state_d = StBranch;
        else if (is_j || is_jal || is_jr) state_d = StJump;
        else begin
          state_d    = StFetch;
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = is_subu ? 3'b001 : 3'b000;
        state_d   = StWbAlu;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = is_lui ? 3'b011 : 3'b010;
        state_d   = StWbAlu;
      end
      StWbAlu: begin
        reg_we     = 1'b1;
        reg_dst    = is_r ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        state_d   = is_lw ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_re  = 1'b1;
        state_d = mem_rdy ? StWbMem : StMemRd;
      end
      StWbMem: begin
        reg_we     = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_we     = 1'b1;
        instr_done = mem_rdy;
        state_d    = mem_rdy ? StFetch : StMemWr;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_we      = zero;
        pc_src     = 2'b01;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        pc_we      = 1'b1;
        pc_src     = is_jr ? 2'b11 : 2'b10;
        instr_done = 1'b1;
        if (is_jal) begin
          reg_we     = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // No side effects may escape while reset is held.
    if (!reset_n) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end

    icount_d = instr_done ? icount_q + 32'd1 : icount_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StFetch;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

  assign icount = icount_q;
  assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: walks each instruction class through its states
// and compares every control output against hand-computed vectors.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        zero, mem_rdy;
  logic        pc_we, ir_we, alu_src_a, ext_op, reg_we, mem_re, mem_we, instr_done, illegal;
  logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0]  alu_op;
  logic [31:0] icount;
  logic [3:0]  state;
  logic [19:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  mc_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr      (instr),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .instr_done (instr_done),
    .illegal    (illegal),
    .icount     (icount),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_we, pc_src, ir_we, alu_op, alu_src_a, alu_src_b, ext_op, reg_we, reg_dst,
                mem_to_reg, mem_re, mem_we, instr_done, illegal};

  function automatic logic [19:0] mk(
    input logic pw, input logic [1:0] ps, input logic iw, input logic [2:0] op,
    input logic sa, input logic [1:0] sb, input logic ex, input logic rw,
    input logic [1:0] rd, input logic [1:0] m2r, input logic re, input logic we,
    input logic dn, input logic il);
    return {pw, ps, iw, op, sa, sb, ex, rw, rd, m2r, re, we, dn, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] s, input logic [19:0] c);
    check({tag, " state"}, {28'd0, s}, {28'd0, state});
    check({tag, " ctl"}, {12'd0, ctl}, {12'd0, c});
  endtask

  // Advance one clock, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] IAddu = 32'h0022_1821;
  localparam logic [31:0] ISubu = 32'h0022_1823;
  localparam logic [31:0] IOri  = 32'h3422_00FF;
  localparam logic [31:0] ILw   = 32'h8C22_0004;
  localparam logic [31:0] ISw   = 32'hAC22_0008;
  localparam logic [31:0] IBeq  = 32'h1022_0003;
  localparam logic [31:0] IJ    = 32'h0800_0010;
  localparam logic [31:0] IJal  = 32'h0C00_0010;
  localparam logic [31:0] IJr   = 32'h03E0_0008;
  localparam logic [31:0] IBad  = 32'hFC00_0000;

  logic [19:0] v_fetch, v_dec;

  initial begin
    v_fetch = mk(1, 2'd0, 1, 3'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
    v_dec   = mk(0, 2'd0, 0, 3'd0, 0, 2'd3, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
    reset_n = 1'b0;
    instr   = IAddu;
    zero    = 1'b0;
    mem_rdy = 1'b0;

    // Reset: FETCH state, enables gated, selects still driven.
    repeat (3) tick();
    chk("reset", 4'd0, mk(0, 2'd0, 0, 3'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0));
    check("reset icount", icount, 32'd0);

    // addu: 0 -> 1 -> 2 -> 7
    reset_n = 1'b1;
    #1;
    chk("addu fetch", 4'd0, v_fetch);
    tick(); chk("addu decode", 4'd1, v_dec);
    tick(); chk("addu exec", 4'd2, mk(0, 2'd0, 0, 3'd0, 1, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0));
    tick(); chk("addu wb", 4'd7, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 1, 2'd1, 2'd0, 0, 0, 1, 0));
    check("addu icount before", icount, 32'd0);
    tick(); check("addu icount", icount, 32'd1);

    // subu
    instr = ISubu;
    tick(); tick();
    chk("subu exec", 4'd2, mk(0, 2'd0, 0, 3'd1, 1, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0));
    tick(); tick(); check("subu icount", icount, 32'd2);

    // lw with two wait cycles: 7 cycles total
    instr = ILw;
    chk("lw fetch", 4'd0, v_fetch);
    tick(); chk("lw decode", 4'd1, v_dec);
    tick(); chk("lw addr", 4'd4, mk(0, 2'd0, 0, 3'd0, 1, 2'd2, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0));
    tick(); chk("lw rd wait1", 4'd5, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0));
    tick(); chk("lw rd wait2", 4'd5, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0));
    tick(); mem_rdy = 1'b1; #1;
    chk("lw rd done", 4'd5, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 1, 0, 0, 0));
    tick(); mem_rdy = 1'b0; #1;
    chk("lw wb", 4'd8, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 1, 2'd0, 2'd1, 0, 0, 1, 0));
    tick(); chk("lw next fetch", 4'd0, v_fetch);
    check("lw icount", icount, 32'd3);

    // sw with one wait cycle; instr_done follows mem_rdy
    instr = ISw;
    tick(); tick();
    chk("sw addr", 4'd4, mk(0, 2'd0, 0, 3'd0, 1, 2'd2, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0));
    tick(); chk("sw wait", 4'd6, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 0));
    tick(); mem_rdy = 1'b1; #1;
    chk("sw done", 4'd6, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 0));
    tick(); mem_rdy = 1'b0; #1;
    chk("sw next fetch", 4'd0, v_fetch);
    check("sw icount", icount, 32'd4);

    // beq taken and not taken
    instr = IBeq;
    tick(); tick(); zero = 1'b1; #1;
    chk("beq taken", 4'd9, mk(1, 2'd1, 0, 3'd1, 1, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 0));
    tick(); zero = 1'b0; #1;
    chk("beq taken next", 4'd0, v_fetch);
    tick(); tick();
    chk("beq not taken", 4'd9, mk(0, 2'd1, 0, 3'd1, 1, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 0));
    tick(); check("beq icount", icount, 32'd6);

    // jal and jr
    instr = IJal;
    tick(); tick();
    chk("jal jump", 4'd10, mk(1, 2'd2, 0, 3'd0, 0, 2'd0, 0, 1, 2'd2, 2'd2, 0, 0, 1, 0));
    tick(); instr = IJr;
    tick(); tick();
    chk("jr jump", 4'd10, mk(1, 2'd3, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 0));
    tick(); check("jr icount", icount, 32'd8);

    // Illegal opcode: two cycles, still retires
    instr = IBad;
    tick();
    chk("illegal decode", 4'd1, mk(0, 2'd0, 0, 3'd0, 0, 2'd3, 0, 0, 2'd0, 2'd0, 0, 0, 1, 1));
    tick(); chk("illegal next", 4'd0, v_fetch);
    check("illegal icount", icount, 32'd9);

    // ori
    instr = IOri;
    tick(); tick();
    chk("ori exec", 4'd3, mk(0, 2'd0, 0, 3'd2, 1, 2'd2, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0));
    tick(); chk("ori wb", 4'd7, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 1, 2'd0, 2'd0, 0, 0, 1, 0));
    tick(); check("ori icount", icount, 32'd10);

    // Reset during a store wait aborts it with no write
    instr = ISw;
    tick(); tick(); tick();
    reset_n = 1'b0; #1;
    chk("reset in sw wait", 4'd6, mk(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0));
    tick(); reset_n = 1'b1; #1;
    chk("after abort", 4'd0, v_fetch);
    check("abort icount", icount, 32'd0);

    // icount wrap: preload all-ones, retire a j
    instr = IJ;
    force dut.icount_q = 32'hFFFF_FFFF;
    tick();
    release dut.icount_q;
    #1;
    check("wrap preload", icount, 32'hFFFF_FFFF);
    tick();
    chk("j jump", 4'd10, mk(1, 2'd2, 0, 3'd0, 0, 2'd0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 0));
    tick(); check("wrap icount", icount, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states. It drives the ALU operation code and operand selects, the PC/IR/register-file/data-memory write enables and the mux selects. Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr. The ALU is shared across states: it computes the PC-relative branch target, addresses and results. A data-memory ready handshake stretches memory states.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock; sole clock
- reset_n  in  1  synchronous, active-low reset
- instr  in  32  IR contents; stable from DECODE onward (IR loads at the end of FETCH)
- zero  in  1  ALU equality flag (Op1 == Op2), sampled only in BRANCH
- mem_rdy  in  1  data memory completed the access this cycle
- pc_we  out  1  PC write enable
- pc_src  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 {PC[31:28], instr[25:0], 2'b00}, 11 GPR[rs]
- ir_we  out  1  IR write enable
- alu_op  out  3  000 add, 001 sub, 010 or, 011 lui; all other codes unused
- alu_src_a  out  1  0 PC, 1 GPR[rs]
- alu_src_b  out  2  00 GPR[rt], 01 const 4, 10 ext(imm16), 11 sext(imm16)<<2
- ext_op  out  1  1 sign-extend, 0 zero-extend imm16
- reg_we  out  1  register file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (already PC+4)
- mem_re  out  1  data memory read request
- mem_we  out  1  data memory write request
- instr_done  out  1  one-cycle pulse in the final state of every instruction
- illegal  out  1  one-cycle pulse in DECODE for unsupported encodings
- icount  out  32  retired-instruction counter
- state  out  4  current state (debug)

## Operation
- Decode: op = instr[31:26], funct = instr[5:0].
  - R-type op 000000 with funct 100001 addu, 100011 subu, 001000 jr.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States (encoding): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10.
- FETCH: ir_we=1, pc_we=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=000. Next state: DECODE.
- DECODE: ALU computes the branch target (alu_src_a=0, alu_src_b=11, add) into ALUOut. Next state by instruction:
  - addu/subu → EXEC_R
  - ori/lui → EXEC_I
  - lw/sw → MEM_ADDR
  - beq → BRANCH
  - j/jal/jr → JUMP
  - otherwise → FETCH, with illegal=1 and instr_done=1
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op = 000 (addu) or 001 (subu). Next state: WB_ALU with reg_dst=01.
- EXEC_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_op = 010 (ori) or 011 (lui). Next state: WB_ALU with reg_dst=00.
- WB_ALU: reg_we=1, mem_to_reg=00, instr_done=1. Next state: FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, add. Next state: MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_re=1 every cycle. Stays in MEM_RD while mem_rdy=0, moves to WB_MEM when mem_rdy=1.
- WB_MEM: reg_we=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next state: FETCH.
- MEM_WR: mem_we=1 every cycle while waiting. When mem_rdy=1, instr_done=1 and next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub. pc_we=zero, pc_src=01, instr_done=1. Next state: FETCH.
- JUMP: pc_we=1, instr_done=1. Next state: FETCH.
  - j: pc_src=10.
  - jal: pc_src=10, plus reg_we=1, reg_dst=10, mem_to_reg=10.
  - jr: pc_src=11.
- Defaults: all enables, selects, ext_op and alu_op are 0 unless listed above.
- Outputs are combinational from state and instr (Moore plus instruction decode). No output depends on mem_rdy except instr_done in MEM_WR. No output depends on zero except pc_we in BRANCH.
- icount increments by 1 on each clock edge where instr_done=1, including illegal encodings. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (reset_n=0 at a rising edge): state=FETCH and icount=0. While reset_n=0, all write enables and mem_re are forced to 0, and instr_done and illegal are forced to 0.
- The first FETCH outputs appear in the cycle after reset_n rises.
- Reset asserted mid-instruction, including during a memory wait, aborts it. No writes occur in the reset cycle.
- Cycle counts with mem_rdy=1 on the first cycle of the memory state:
  - lw 5; sw 4; addu/subu/ori/lui 4; beq/j/jal/jr 3; illegal 2.
  - Each cycle of mem_rdy=0 adds one cycle.
- Back-to-back instructions: the edge ending the final state enters FETCH. There are no idle cycles.

## Test plan
- Reset: hold reset_n=0 for 3 cycles in DECODE-eligible conditions → state=0, pc_we=ir_we=reg_we=mem_we=0, icount=0. After release, the first cycle has ir_we=pc_we=1.
- addu $3,$1,$2 (0x00221821):
  - States 0→1→2→7.
  - In EXEC_R: alu_op=000, alu_src_b=00.
  - In WB_ALU: reg_we=1, reg_dst=01, instr_done=1.
  - icount becomes 1.
- lw with mem_rdy held low for 2 cycles in MEM_RD:
  - mem_re=1 for 3 cycles, then WB_MEM with mem_to_reg=01.
  - Total 7 cycles.
- sw with mem_rdy=0 then 1: mem_we=1 for 2 consecutive cycles, and instr_done coincides with mem_rdy=1.
- beq:
  - zero=1 in BRANCH → pc_we=1, pc_src=01.
  - zero=0 → pc_we=0.
  - Both cases take 3 cycles.
- jal 0x0C000010 → JUMP with pc_src=10, reg_we=1, reg_dst=10, mem_to_reg=10.
- Illegal op 0x3F → illegal=1 in DECODE, next state FETCH, icount +1.
- Wrap: preload icount=0xFFFFFFFF via the bench → 0 after the next instruction.
